// File: rtl/osd_dem_uart_bb_arb.sv
// osd_dem_uart_bb_arb
// Round-robin arbiter and single-outstanding transaction sequencer for the
// bus-bridge (16550 register) port of the UART debug emulation module.
// NREQ masters share the port; one access runs at a time through
// IDLE -> ISSUE -> (WAIT) -> DONE, and the winner gets a grant pulse when its
// access is issued and an acknowledge pulse when it completes.

module osd_dem_uart_bb_arb #(
    parameter int NREQ   = 2,
    parameter int DW     = 32,
    parameter int AW     = 4,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ-1:0]      req_we_i,
    input  logic [NREQ*AW-1:0]   req_addr_i,
    input  logic [NREQ*DW-1:0]   req_din_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic [NREQ-1:0]      ack_o,
    output logic [DW-1:0]        rdata_o,
    output logic                 busy_o,
    output logic [AW-1:0]        bb_addr_o,
    output logic [DW-1:0]        bb_din_o,
    output logic                 bb_en_o,
    output logic                 bb_we_o,
    input  logic [DW-1:0]        bb_dout_i
);

    // Width of a requester index and of the read-latency countdown.
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [PW-1:0]       r_ptr;
    logic [PW-1:0]       r_winner;
    logic [CW-1:0]       r_cnt;
    logic [NREQ-1:0]     r_gnt;
    logic [NREQ-1:0]     r_ack;
    logic [DW-1:0]       r_rdata;
    logic                r_busy;
    logic [AW-1:0]       r_bbAddr;
    logic [DW-1:0]       r_bbDin;
    logic                r_bbEn;
    logic                r_bbWe;

    logic                w_found;
    logic [PW-1:0]       w_winner;
    logic [PW-1:0]       w_ptrNext;
    logic [NREQ-1:0]     w_winOneHot;
    logic [NREQ-1:0]     w_ackOneHot;
    int                  w_idx;

    // Round-robin search: scan req_i from r_ptr upward, wrapping, first set bit wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!w_found && req_i[w_idx]) begin
                w_found  = 1'b1;
                w_winner = PW'(w_idx);
            end
        end
    end

    // Pointer moves to the slot just after the winner so it has lowest priority next time.
    always_comb begin
        if (int'(w_winner) == NREQ - 1) begin
            w_ptrNext = '0;
        end else begin
            w_ptrNext = w_winner + PW'(1);
        end
        w_winOneHot = NREQ'(1) << w_winner;
        w_ackOneHot = NREQ'(1) << r_winner;
    end

    // Transaction sequencer; every output is a register updated here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_winner <= '0;
            r_cnt    <= '0;
            r_gnt    <= '0;
            r_ack    <= '0;
            r_rdata  <= '0;
            r_busy   <= 1'b0;
            r_bbAddr <= '0;
            r_bbDin  <= '0;
            r_bbEn   <= 1'b0;
            r_bbWe   <= 1'b0;
        end else begin
            r_gnt  <= '0;
            r_ack  <= '0;
            r_bbEn <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_bbWe   <= req_we_i[w_winner];
                        r_bbAddr <= req_addr_i[w_winner*AW +: AW];
                        r_bbDin  <= req_din_i[w_winner*DW +: DW];
                        r_winner <= w_winner;
                        r_ptr    <= w_ptrNext;
                        r_gnt    <= w_winOneHot;
                        r_bbEn   <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_bbWe) begin
                        r_ack   <= w_ackOneHot;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt   <= CW'(RD_LAT - 1);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_rdata <= bb_dout_i;
                        r_ack   <= w_ackOneHot;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt_o     = r_gnt;
    assign ack_o     = r_ack;
    assign rdata_o   = r_rdata;
    assign busy_o    = r_busy;
    assign bb_addr_o = r_bbAddr;
    assign bb_din_o  = r_bbDin;
    assign bb_en_o   = r_bbEn;
    assign bb_we_o   = r_bbWe;

endmodule

// File: tb/tb_osd_dem_uart_bb_arb.sv
// tb_osd_dem_uart_bb_arb
// Directed bench for the bus-bridge arbiter: one instance with RD_LAT=1 and a
// second with RD_LAT=3. A tiny bus-bridge model returns read data only in the
// cycle it is due and a poison value otherwise, so mistimed captures show up.

module tb_osd_dem_uart_bb_arb;

    localparam logic [31:0] POISON = 32'hDEADBEEF;

    logic        clk;
    logic        rst;

    // Signals for the RD_LAT=1 instance
    logic [1:0]  req;
    logic [1:0]  reqWe;
    logic [7:0]  reqAddr;
    logic [63:0] reqDin;
    logic [1:0]  gnt;
    logic [1:0]  ack;
    logic [31:0] rdata;
    logic        busy;
    logic [3:0]  bbAddr;
    logic [31:0] bbDin;
    logic        bbEn;
    logic        bbWe;
    logic [31:0] bbDout;
    logic [31:0] rdVal;
    logic        rdStage;

    // Signals for the RD_LAT=3 instance
    logic [1:0]  req3;
    logic [1:0]  reqWe3;
    logic [7:0]  reqAddr3;
    logic [63:0] reqDin3;
    logic [1:0]  gnt3;
    logic [1:0]  ack3;
    logic [31:0] rdata3;
    logic        busy3;
    logic [3:0]  bbAddr3;
    logic [31:0] bbDin3;
    logic        bbEn3;
    logic        bbWe3;
    logic [31:0] bbDout3;
    logic [31:0] rdVal3;
    logic [2:0]  rdStage3;

    int total;
    int bad;

    osd_dem_uart_bb_arb #(.NREQ(2), .DW(32), .AW(4), .RD_LAT(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req),
        .req_we_i   (reqWe),
        .req_addr_i (reqAddr),
        .req_din_i  (reqDin),
        .gnt_o      (gnt),
        .ack_o      (ack),
        .rdata_o    (rdata),
        .busy_o     (busy),
        .bb_addr_o  (bbAddr),
        .bb_din_o   (bbDin),
        .bb_en_o    (bbEn),
        .bb_we_o    (bbWe),
        .bb_dout_i  (bbDout)
    );

    osd_dem_uart_bb_arb #(.NREQ(2), .DW(32), .AW(4), .RD_LAT(3)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req3),
        .req_we_i   (reqWe3),
        .req_addr_i (reqAddr3),
        .req_din_i  (reqDin3),
        .gnt_o      (gnt3),
        .ack_o      (ack3),
        .rdata_o    (rdata3),
        .busy_o     (busy3),
        .bb_addr_o  (bbAddr3),
        .bb_din_o   (bbDin3),
        .bb_en_o    (bbEn3),
        .bb_we_o    (bbWe3),
        .bb_dout_i  (bbDout3)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus-bridge model: read data appears exactly RD_LAT cycles after the enable cycle
    always_ff @(posedge clk) begin
        rdStage  <= bbEn && !bbWe;
        rdStage3 <= {rdStage3[1:0], bbEn3 && !bbWe3};
    end
    assign bbDout  = rdStage     ? rdVal  : POISON;
    assign bbDout3 = rdStage3[2] ? rdVal3 : POISON;

    // Single comparison point: counts, and reports any mismatch
    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive the request inputs of the RD_LAT=1 instance
    task automatic applyStimulus(input logic [1:0] r, input logic [1:0] we,
                                 input logic [7:0] addr, input logic [63:0] din);
        req     = r;
        reqWe   = we;
        reqAddr = addr;
        reqDin  = din;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b0;
        rdVal    = POISON;
        rdVal3   = POISON;
        applyStimulus(2'b00, 2'b00, 8'h00, 64'h0);
        req3     = 2'b00;
        reqWe3   = 2'b00;
        reqAddr3 = 8'h00;
        reqDin3  = 64'h0;
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("rst_gnt",   {62'd0, gnt}, 64'd0);
        checkOutput("rst_ack",   {62'd0, ack}, 64'd0);
        checkOutput("rst_rdata", {32'd0, rdata}, 64'd0);
        checkOutput("rst_bus",   {26'd0, bbEn, bbWe, bbAddr, busy}, 64'd0);
        checkOutput("rst_din",   {32'd0, bbDin}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single write from requester 0
        applyStimulus(2'b01, 2'b01, 8'h03, 64'h0000_0000_0000_0083);
        @(negedge clk);
        checkOutput("wr_gnt",   {62'd0, gnt}, 64'h1);
        checkOutput("wr_en",    {63'd0, bbEn}, 64'h1);
        checkOutput("wr_we",    {63'd0, bbWe}, 64'h1);
        checkOutput("wr_addr",  {60'd0, bbAddr}, 64'h3);
        checkOutput("wr_din",   {32'd0, bbDin}, 64'h83);
        checkOutput("wr_ack1",  {62'd0, ack}, 64'h0);
        applyStimulus(2'b00, 2'b00, 8'h00, 64'h0);
        @(negedge clk);
        checkOutput("wr_ack",   {62'd0, ack}, 64'h1);
        checkOutput("wr_en2",   {63'd0, bbEn}, 64'h0);
        checkOutput("wr_rdata", {32'd0, rdata}, 64'h0);
        @(negedge clk);
        checkOutput("wr_idle",  {62'd0, ack, busy, gnt[0]}, 64'h0);

        // Single read from requester 1, address 5
        rdVal = 32'h6060_6060;
        applyStimulus(2'b10, 2'b00, 8'h50, 64'h0);
        @(negedge clk);
        checkOutput("rd_gnt",   {62'd0, gnt}, 64'h2);
        checkOutput("rd_en",    {62'd0, bbEn, bbWe}, 64'h2);
        checkOutput("rd_addr",  {60'd0, bbAddr}, 64'h5);
        applyStimulus(2'b00, 2'b00, 8'h00, 64'h0);
        @(negedge clk);
        checkOutput("rd_wait",  {61'd0, bbEn, ack}, 64'h0);
        checkOutput("rd_hold",  {60'd0, bbAddr}, 64'h5);
        @(negedge clk);
        checkOutput("rd_ack",   {62'd0, ack}, 64'h2);
        checkOutput("rd_rdata", {32'd0, rdata}, 64'h6060_6060);
        @(negedge clk);
        checkOutput("rd_idle",  {62'd0, busy, ack[1]}, 64'h0);
        checkOutput("rd_keep",  {32'd0, rdata}, 64'h6060_6060);

        // Continuous contention: both write, grants alternate 0,1,0,1
        applyStimulus(2'b11, 2'b11, 8'hBA, 64'h0000_0011_0000_0010);
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            checkOutput($sformatf("ct_gnt%0d", t), {62'd0, gnt}, (t % 2 == 0) ? 64'h1 : 64'h2);
            checkOutput($sformatf("ct_addr%0d", t), {60'd0, bbAddr}, (t % 2 == 0) ? 64'hA : 64'hB);
            @(negedge clk);
            checkOutput($sformatf("ct_ack%0d", t), {62'd0, ack}, (t % 2 == 0) ? 64'h1 : 64'h2);
            @(negedge clk);
            checkOutput($sformatf("ct_idle%0d", t), {61'd0, busy, gnt}, 64'h0);
            if (t == 3) begin
                applyStimulus(2'b00, 2'b00, 8'h00, 64'h0);
            end
        end
        checkOutput("ct_rdata", {32'd0, rdata}, 64'h6060_6060);

        // Withdrawal: requester 0 asks during requester 1's WAIT and drops before IDLE
        rdVal = 32'h0BAD_F00D;
        applyStimulus(2'b10, 2'b00, 8'h70, 64'h0);
        @(negedge clk);
        checkOutput("wd_gnt", {62'd0, gnt}, 64'h2);
        applyStimulus(2'b00, 2'b00, 8'h70, 64'h0);
        @(negedge clk);
        applyStimulus(2'b01, 2'b01, 8'h7E, 64'h0000_0000_0000_00EE);
        @(negedge clk);
        checkOutput("wd_ack",  {62'd0, ack}, 64'h2);
        checkOutput("wd_gnt2", {62'd0, gnt}, 64'h0);
        applyStimulus(2'b00, 2'b00, 8'h00, 64'h0);
        @(negedge clk);
        checkOutput("wd_idle", {61'd0, busy, gnt}, 64'h0);
        @(negedge clk);
        checkOutput("wd_none", {60'd0, bbEn, busy, gnt}, 64'h0);
        checkOutput("wd_rdata", {32'd0, rdata}, 64'h0BAD_F00D);

        // Reset mid-read: requester 0 reads (ptr becomes 1), reset hits in WAIT
        applyStimulus(2'b01, 2'b00, 8'h04, 64'h0);
        @(negedge clk);
        checkOutput("rr_gnt", {62'd0, gnt}, 64'h1);
        applyStimulus(2'b00, 2'b00, 8'h00, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rr_abort", {59'd0, bbEn, busy, ack, gnt[0]}, 64'h0);
        checkOutput("rr_rdata", {32'd0, rdata}, 64'h0);
        @(negedge clk);
        checkOutput("rr_noack", {62'd0, ack}, 64'h0);
        rst = 1'b1;
        @(negedge clk);

        // Fresh read after reset with both requesting: ptr back at 0 so requester 0 wins
        rdVal = 32'h1234_5678;
        applyStimulus(2'b11, 2'b00, 8'h92, 64'h0);
        @(negedge clk);
        checkOutput("fr_gnt",  {62'd0, gnt}, 64'h1);
        checkOutput("fr_addr", {60'd0, bbAddr}, 64'h2);
        applyStimulus(2'b00, 2'b00, 8'h00, 64'h0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("fr_ack",   {62'd0, ack}, 64'h1);
        checkOutput("fr_rdata", {32'd0, rdata}, 64'h1234_5678);
        @(negedge clk);
        checkOutput("fr_idle",  {63'd0, busy}, 64'h0);

        // RD_LAT=3 instance: capture 3 cycles after enable, ack at cycle 5
        rdVal3   = 32'hA5A5_0003;
        req3     = 2'b01;
        reqWe3   = 2'b00;
        reqAddr3 = 8'h07;
        @(negedge clk);
        checkOutput("l3_gnt", {62'd0, gnt3}, 64'h1);
        checkOutput("l3_en",  {63'd0, bbEn3}, 64'h1);
        req3 = 2'b00;
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            checkOutput($sformatf("l3_wait%0d", c), {61'd0, bbEn3, ack3}, 64'h0);
        end
        @(negedge clk);
        checkOutput("l3_ack",   {62'd0, ack3}, 64'h1);
        checkOutput("l3_rdata", {32'd0, rdata3}, 64'hA5A5_0003);
        @(negedge clk);
        checkOutput("l3_idle",  {62'd0, busy3, ack3[0]}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
